spike_rate_decoder: RTL

Receive-side counterpart to the LIF neuron: it takes the neuron's 1-bit spike train and turns it back into an 8-bit firing-rate value by counting spikes over a fixed window of clock cycles. The block sits downstream of the neuron's spike output, on the bidirectional I/O side of the top level. It hands each completed rate sample to a consumer over a valid/ready handshake.

---
 rtl/lif_pkg.sv | 29 ++
 rtl/sat_counter.sv | 54 +++++
 rtl/spike_rate_decoder.sv | 239 +++++++++++++++++++++++
 3 files changed

// File: rtl/lif_pkg.sv
// ============================================================================
// Package : lif_pkg
// Purpose : Types and default constants shared by the LIF neuron and the
//           spike_rate_decoder (FSM state enum, default widths/window size).
// Ports   : none (package)
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package lif_pkg;

  // Common rate / input-current width, shared with the neuron side.
  localparam int unsigned RATE_W = 8;

  // Defaults for the rate decoder parameters.
  localparam int unsigned WINDOW_LOG2_DEFAULT = 8;
  localparam int unsigned COUNT_W_DEFAULT     = RATE_W;
  localparam int unsigned ISI_W_DEFAULT       = 8;

  // Decoder FSM states.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    COUNT = 1'b1
  } state_e;

endpackage

`default_nettype wire

// File: rtl/sat_counter.sv
// ============================================================================
// Module  : sat_counter
// Purpose : Up-counter that sticks at its all-ones value. Exposes the value
//           the counter would take this cycle (increment applied, clear not
//           applied) so a caller can capture a count that includes the
//           current cycle's event on the same edge that clears the counter.
// Ports   : clk    - clock
//           rst_n  - asynchronous active-low reset
//           clr_i  - synchronous clear (wins over increment)
//           inc_i  - increment request
//           nxt_o  - saturated count including this cycle's increment
//           sat_o  - nxt_o is at the saturation value
// Options : none
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         inc_i,
  output logic [W-1:0] nxt_o,
  output logic         sat_o
);

  localparam logic [W-1:0] CNT_MAX = '1;

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    nxt_o = cnt_q;
    if (inc_i && (cnt_q != CNT_MAX)) begin
      nxt_o = cnt_q + W'(1);
    end
    cnt_d = clr_i ? '0 : nxt_o;
  end

  assign sat_o = (nxt_o == CNT_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

`default_nettype wire

// File: rtl/spike_rate_decoder.sv
// ============================================================================
// Module  : spike_rate_decoder
// Purpose : Converts a 1-bit spike train into a firing-rate sample by counting
//           spikes over fixed windows of 2**WINDOW_LOG2 cycles. Each finished
//           sample is offered on a valid/ready handshake; an unconsumed
//           sample that gets overwritten raises a sticky overrun flag.
// Ports   : clk, rst_n (async, active low)
//           ena        - enable; low returns the FSM to IDLE
//           spike      - spike input, one spike per high cycle
//           rate_ready - consumer ready
//           ovr_clr    - clear the sticky overrun flag
//           rate       - spike count of last completed window
//           rate_valid - rate holds an unconsumed sample
//           sat        - window that produced rate saturated
//           overrun    - sticky: unconsumed sample was overwritten
//           busy       - FSM is in COUNT
//           isi        - last inter-spike interval   (SPIKE_ISI_EN only)
//           isi_valid  - one-cycle pulse on isi update (SPIKE_ISI_EN only)
// Options : `define SPIKE_ISI_EN adds the inter-spike-interval measurement
//           (ISI_W parameter, isi/isi_valid ports).
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module spike_rate_decoder
  import lif_pkg::*;
#(
  parameter int unsigned WINDOW_LOG2 = WINDOW_LOG2_DEFAULT,
  parameter int unsigned COUNT_W     = COUNT_W_DEFAULT
`ifdef SPIKE_ISI_EN
  ,
  parameter int unsigned ISI_W       = ISI_W_DEFAULT
`endif
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               ena,
  input  logic               spike,
  input  logic               rate_ready,
  input  logic               ovr_clr,
  output logic [COUNT_W-1:0] rate,
  output logic               rate_valid,
  output logic               sat,
  output logic               overrun,
  output logic               busy
`ifdef SPIKE_ISI_EN
  ,
  output logic [ISI_W-1:0]   isi,
  output logic               isi_valid
`endif
);

  localparam logic [WINDOW_LOG2-1:0] WIN_LAST = '1;

  // --------------------------------------------------------------------------
  // Enable register and FSM. The FSM acts on the registered enable, so the
  // first COUNT cycle starts one edge after ena is sampled high.
  // --------------------------------------------------------------------------
  logic   ena_q;
  state_e state_q;
  state_e state_d;
  logic   counting;

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (ena_q)  state_d = COUNT;
      COUNT:   if (!ena_q) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ena_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      ena_q   <= ena;
      state_q <= state_d;
    end
  end

  assign counting = (state_q == COUNT);
  assign busy     = counting;

  // --------------------------------------------------------------------------
  // Window counter: wraps naturally from all-ones to zero, so the next window
  // starts on the edge right after the terminal cycle.
  // --------------------------------------------------------------------------
  logic [WINDOW_LOG2-1:0] win_q;
  logic [WINDOW_LOG2-1:0] win_d;
  logic                   terminal;

  assign win_d    = counting ? (win_q + WINDOW_LOG2'(1)) : '0;
  assign terminal = counting && (win_q == WIN_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      win_q <= '0;
    end else begin
      win_q <= win_d;
    end
  end

  // --------------------------------------------------------------------------
  // Spike counter. Its next value already includes this cycle's spike, which
  // is what the terminal cycle captures.
  // --------------------------------------------------------------------------
  logic [COUNT_W-1:0] cnt_nxt;
  logic               cnt_sat;

  sat_counter #(
    .W (COUNT_W)
  ) u_spike_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!counting || terminal),
    .inc_i (counting && spike),
    .nxt_o (cnt_nxt),
    .sat_o (cnt_sat)
  );

  // --------------------------------------------------------------------------
  // Output sample register and handshake.
  // --------------------------------------------------------------------------
  logic [COUNT_W-1:0] rate_q;
  logic [COUNT_W-1:0] rate_d;
  logic               rate_valid_q;
  logic               rate_valid_d;
  logic               sat_q;
  logic               sat_d;
  logic               overrun_q;
  logic               overrun_d;

  always_comb begin
    rate_d       = rate_q;
    sat_d        = sat_q;
    rate_valid_d = rate_valid_q;
    overrun_d    = overrun_q;

    if (rate_valid_q && rate_ready) begin
      rate_valid_d = 1'b0;
    end
    if (ovr_clr) begin
      overrun_d = 1'b0;
    end
    if (terminal) begin
      rate_d       = cnt_nxt;
      sat_d        = cnt_sat;
      rate_valid_d = 1'b1;
      // Ordered after the clear so a same-edge overwrite keeps the flag set.
      if (rate_valid_q && !rate_ready) begin
        overrun_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rate_q       <= '0;
      sat_q        <= 1'b0;
      rate_valid_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      rate_q       <= rate_d;
      sat_q        <= sat_d;
      rate_valid_q <= rate_valid_d;
      overrun_q    <= overrun_d;
    end
  end

  assign rate       = rate_q;
  assign sat        = sat_q;
  assign rate_valid = rate_valid_q;
  assign overrun    = overrun_q;

`ifdef SPIKE_ISI_EN
  // --------------------------------------------------------------------------
  // Inter-spike interval. The counter is cleared by each spike and counts
  // every COUNT cycle, so its incremented value in the cycle of the next
  // spike is the distance between the two spikes (adjacent spikes give 1).
  // --------------------------------------------------------------------------
  logic [ISI_W-1:0] isi_nxt;
  logic             isi_sat;
  logic [ISI_W-1:0] isi_q;
  logic [ISI_W-1:0] isi_d;
  logic             isi_valid_q;
  logic             isi_valid_d;
  logic             seen_q;
  logic             seen_d;

  sat_counter #(
    .W (ISI_W)
  ) u_isi_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (!counting || spike),
    .inc_i (counting),
    .nxt_o (isi_nxt),
    .sat_o (isi_sat)
  );

  always_comb begin
    isi_d       = isi_q;
    seen_d      = seen_q;
    isi_valid_d = 1'b0;
    if (!counting) begin
      seen_d = 1'b0;
    end else if (spike) begin
      seen_d = 1'b1;
      // The first spike since entering COUNT only opens the interval.
      if (seen_q) begin
        isi_valid_d = 1'b1;
        isi_d       = isi_sat ? '1 : isi_nxt;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      isi_q       <= '0;
      isi_valid_q <= 1'b0;
      seen_q      <= 1'b0;
    end else begin
      isi_q       <= isi_d;
      isi_valid_q <= isi_valid_d;
      seen_q      <= seen_d;
    end
  end

  assign isi       = isi_q;
  assign isi_valid = isi_valid_q;
`else
  // Interval measurement not built: no isi/isi_valid ports or logic.
`endif

endmodule

`default_nettype wire
